// File: rtl/spi_clk_gen_p_if.sv
// Control and serial-clock signal bundle between the Wishbone-side registers
// and the SPI clock generator; master = register side, slave = generator.
interface spi_clk_gen_p_if #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 7
);
  logic             go;
  logic             stop;
  logic [DIV_W-1:0] divider;
  logic             cpol;
  logic [LEN_W-1:0] char_len;
  logic             sclk_out;
  logic             pos_edge;
  logic             neg_edge;
  logic             tip;
  logic             last_bit;
  logic             done;

  modport master (
    output go, stop, divider, cpol, char_len,
    input  sclk_out, pos_edge, neg_edge, tip, last_bit, done
  );

  modport slave (
    input  go, stop, divider, cpol, char_len,
    output sclk_out, pos_edge, neg_edge, tip, last_bit, done
  );
endinterface

// File: rtl/spi_clk_gen_p.sv
// Programmable SPI serial-clock generator: divider, CPOL, transfer length with
// automatic stop, edge strobes for the shifter, and abort support.
module spi_clk_gen_p #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 7
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst_n,
  spi_clk_gen_p_if.slave   bus
);
  localparam int EW = LEN_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [EW-1:0]    edges_left;
  logic             cpol_q;
  logic             sclk_q;
  logic [LEN_W:0]   n_bits;

  // A char_len of zero selects the full 2^LEN_W-bit transfer.
  always_comb begin
    n_bits = {1'b0, bus.char_len};
    if (bus.char_len == '0) n_bits = {1'b1, {LEN_W{1'b0}}};
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= '0;
      edges_left <= '0;
      cpol_q     <= 1'b0;
      sclk_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            div_q      <= bus.divider;
            cpol_q     <= bus.cpol;
            cnt        <= bus.divider;
            edges_left <= {n_bits, 1'b0};
            sclk_q     <= bus.cpol;
            state      <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state      <= IDLE;
            sclk_q     <= cpol_q;
            cnt        <= '0;
            edges_left <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
          end else begin
            cnt        <= div_q;
            sclk_q     <= ~sclk_q;
            edges_left <= edges_left - EW'(1);
            // Even edge count leaves sclk back at cpol_q on entry to DONE.
            if (edges_left == EW'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk_out = sclk_q;
  assign bus.pos_edge = (state == RUN) && (cnt == '0) && !sclk_q;
  assign bus.neg_edge = (state == RUN) && (cnt == '0) &&  sclk_q;
  assign bus.tip      = (state == RUN);
  assign bus.last_bit = (state == RUN) && (edges_left <= EW'(2));
  assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_spi_clk_gen_p.sv
// Self-checking bench for spi_clk_gen_p: per-cycle comparison of all outputs
// against an arithmetic timeline model of each transfer.
module tb_spi_clk_gen_p;
  localparam int DIV_W = 16;
  localparam int LEN_W = 7;

  logic wb_clk_in = 1'b0;
  logic wb_rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 wb_clk_in = ~wb_clk_in;

  spi_clk_gen_p_if #(.DIV_W(DIV_W), .LEN_W(LEN_W)) bus ();

  spi_clk_gen_p #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .wb_clk_in (wb_clk_in),
    .wb_rst_n  (wb_rst_n),
    .bus       (bus)
  );

  // Output vector order: {sclk_out, pos_edge, neg_edge, tip, last_bit, done}
  function automatic logic [5:0] dut_vec();
    return {bus.sclk_out, bus.pos_edge, bus.neg_edge, bus.tip, bus.last_bit, bus.done};
  endfunction

  // Expected outputs t cycles after the go edge, from the transfer timeline:
  // a toggle every d+1 cycles, 2n toggles, then one done cycle.
  function automatic logic [5:0] model(input int d, input int n, input bit cp, input int t);
    int   total;
    int   tog;
    logic s, st, lb;
    total = 2 * n * (d + 1);
    if (t < total) begin
      tog = t / (d + 1);
      s   = cp ^ tog[0];
      st  = ((t % (d + 1)) == d);
      lb  = ((2 * n - tog) <= 2);
      return {s, st & ~s, st & s, 1'b1, lb, 1'b0};
    end else if (t == total) begin
      return {cp, 4'b0000, 1'b1};
    end
    return {cp, 5'b00000};
  endfunction

  task automatic start_go(input int d, input int len, input bit cp);
    @(negedge wb_clk_in);
    bus.divider  = DIV_W'(d);
    bus.char_len = LEN_W'(len);
    bus.cpol     = cp;
    bus.stop     = 1'b0;
    bus.go       = 1'b1;
    @(posedge wb_clk_in);
    #1;
  endtask

  // Called one step after the go edge; returns after the last sample without advancing.
  task automatic check_run(input int d, input int len, input bit cp, input int stop_t,
                           input bit release_go, input bit scramble, input string name,
                           output int npos, output int nneg);
    int n, total, last_t;
    logic [5:0] exp_v, got_v;
    n      = (len == 0) ? (1 << LEN_W) : len;
    total  = 2 * n * (d + 1);
    last_t = (stop_t >= 0) ? stop_t + 1 : total + 1;
    npos   = 0;
    nneg   = 0;
    for (int t = 0; t <= last_t; t++) begin
      if (stop_t >= 0 && t >= stop_t) exp_v = {cp, 5'b00000};
      else                            exp_v = model(d, n, cp, t);
      got_v = dut_vec();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s t=%0d got=%b expected=%b (sclk,pos,neg,tip,last,done)",
                 name, t, got_v, exp_v);
      end
      npos += int'(got_v[4]);
      nneg += int'(got_v[3]);
      if (release_go && t == 0) bus.go = 1'b0;
      if (scramble && t < total - 1) begin
        bus.divider  = DIV_W'($urandom);
        bus.char_len = LEN_W'($urandom);
        bus.cpol     = 1'($urandom);
      end else if (scramble && t == total - 1) begin
        bus.divider  = DIV_W'(d);
        bus.char_len = LEN_W'(len);
        bus.cpol     = cp;
      end
      // Aborts fire at stop_t; otherwise stop is held through DONE/IDLE, where it must be ignored.
      bus.stop = (stop_t >= 0) ? (t == stop_t - 1) : (t >= total);
      if (t < last_t) begin
        @(posedge wb_clk_in);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got_v;
    bus.go = 1'b1; bus.stop = 1'b0; bus.cpol = 1'b1;
    bus.divider = '0; bus.char_len = LEN_W'(1);
    #12;
    got_v = dut_vec();
    checks++;
    if (got_v !== 6'b0) begin
      errors++;
      $display("FAIL reset_state got=%b expected=%b", got_v, 6'b0);
    end
    bus.go = 1'b0;
    @(negedge wb_clk_in);
    wb_rst_n = 1'b1;
    @(posedge wb_clk_in);
    #1;
    got_v = dut_vec();
    checks++;
    if (got_v !== 6'b0) begin
      errors++;
      $display("FAIL reset_release_idle got=%b expected=%b", got_v, 6'b0);
    end
  endtask

  task automatic test_basic();
    int p, ng;
    start_go(1, 2, 1'b0);
    check_run(1, 2, 1'b0, -1, 1'b1, 1'b0, "basic_cpol0_d1_n2", p, ng);
    start_go(0, 1, 1'b1);
    check_run(0, 1, 1'b1, -1, 1'b1, 1'b0, "cpol1_d0_n1", p, ng);
  endtask

  task automatic test_full_length();
    int p, ng;
    start_go(0, 0, 1'b0);
    check_run(0, 0, 1'b0, -1, 1'b1, 1'b0, "len0_full", p, ng);
    checks++;
    if (p !== 128) begin
      errors++;
      $display("FAIL len0_pos_count got=%0d expected=128", p);
    end
    checks++;
    if (ng !== 128) begin
      errors++;
      $display("FAIL len0_neg_count got=%0d expected=128", ng);
    end
  endtask

  task automatic test_stop();
    int p, ng;
    start_go(1, 2, 1'b0);
    check_run(1, 2, 1'b0, 3, 1'b1, 1'b0, "stop_at_e3", p, ng);
    start_go(1, 2, 1'b0);
    check_run(1, 2, 1'b0, -1, 1'b1, 1'b0, "after_stop_restart", p, ng);
  endtask

  task automatic test_back_to_back();
    int p, ng;
    start_go(2, 3, 1'b0);
    check_run(2, 3, 1'b0, -1, 1'b0, 1'b1, "held_go_first", p, ng);
    @(posedge wb_clk_in);
    #1;
    check_run(2, 3, 1'b0, -1, 1'b1, 1'b0, "held_go_second", p, ng);
  endtask

  task automatic test_async_reset();
    logic [5:0] got_v;
    int p, ng;
    start_go(3, 4, 1'b1);
    repeat (5) @(posedge wb_clk_in);
    #3;
    wb_rst_n = 1'b0;
    #1;
    got_v = dut_vec();
    checks++;
    if (got_v !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_midrun got=%b expected=%b", got_v, 6'b0);
    end
    bus.go = 1'b0;
    @(negedge wb_clk_in);
    wb_rst_n = 1'b1;
    @(posedge wb_clk_in);
    #1;
    got_v = dut_vec();
    checks++;
    if (got_v !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_after got=%b expected=%b", got_v, 6'b0);
    end
    start_go(2, 2, 1'b1);
    check_run(2, 2, 1'b1, -1, 1'b1, 1'b0, "post_reset_cpol1", p, ng);
  endtask

  task automatic test_random();
    int d, len, n, stop_t, p, ng;
    bit cp;
    for (int i = 0; i < 10; i++) begin
      d      = $urandom_range(0, 4);
      len    = $urandom_range(1, 5);
      cp     = 1'($urandom);
      n      = len;
      stop_t = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * n * (d + 1) - 1) : -1;
      start_go(d, len, cp);
      check_run(d, len, cp, stop_t, 1'b1, 1'b1, $sformatf("random_%0d", i), p, ng);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_length();
    test_stop();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
